// File: rtl/biquad8_pole_coeff_loader.sv
// biquad8_pole_coeff_loader
// Holds a software-written staging copy of the pole FIR coefficients, snapshots
// it on apply, streams the snapshot into the FIR's F and G B-cascade chains
// (cross DSP first, then the chain values from the far end down to index 0),
// delays the data to line up with the FIR's write-enable pipeline, and finally
// raises a single update strobe so every B2 register switches together.
module biquad8_pole_coeff_loader #(
  parameter int FLEN      = 7,
  parameter int GLEN      = 8,
  parameter int CW        = 18,
  parameter int DAT_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stg_wr_i,
  input  logic [4:0]    stg_adr_i,
  input  logic [CW-1:0] stg_dat_i,
  input  logic          apply_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [4:0]    coeff_adr_o,
  output logic          coeff_wr_o,
  output logic          coeff_update_o,
  output logic [CW-1:0] coeff_dat_o
);

  localparam logic [4:0] L_FLEN       = 5'(FLEN);
  localparam logic [4:0] L_GLEN       = 5'(GLEN);
  localparam logic [4:0] L_GBASE      = 5'd16;
  localparam logic [4:0] L_DRAIN_LAST = 5'((DAT_DELAY > 1) ? (DAT_DELAY - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_F,
    S_LOAD_G,
    S_DRAIN,
    S_UPDATE
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [4:0]    r_idx;
  logic [4:0]    w_nextIdx;
  logic          r_pending;
  logic          w_pendingNext;
  logic          r_done;
  logic          w_snapshot;
  logic          w_wr;
  logic          w_update;
  logic [4:0]    w_adr;
  logic [4:0]    w_fSel;
  logic [4:0]    w_gSel;
  logic [CW-1:0] w_wrDat;

  logic [CW-1:0] r_fStg     [0:FLEN];
  logic [CW-1:0] r_gStg     [0:GLEN];
  logic [CW-1:0] w_fStgNext [0:FLEN];
  logic [CW-1:0] w_gStgNext [0:GLEN];
  logic [CW-1:0] r_fAct     [0:FLEN];
  logic [CW-1:0] r_gAct     [0:GLEN];
  logic [CW-1:0] r_datPipe  [0:DAT_DELAY-1];

  // Staging file with this cycle's write merged in, so a snapshot taken in the
  // same cycle as a write sees the new value.
  always_comb begin
    for (int k = 0; k <= FLEN; k++) begin
      w_fStgNext[k] = r_fStg[k];
      if (stg_wr_i && (stg_adr_i == 5'(k))) begin
        w_fStgNext[k] = stg_dat_i;
      end
    end
    for (int k = 0; k <= GLEN; k++) begin
      w_gStgNext[k] = r_gStg[k];
      if (stg_wr_i && (stg_adr_i == (L_GBASE + 5'(k)))) begin
        w_gStgNext[k] = stg_dat_i;
      end
    end
  end

  // Next-state logic and the write-side outputs of the load sequencer.
  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_snapshot  = 1'b0;
    w_wr        = 1'b0;
    w_adr       = 5'd0;
    w_update    = 1'b0;
    w_fSel      = 5'd0;
    w_gSel      = 5'd0;
    case (r_state)
      S_IDLE: begin
        if (apply_i) begin
          w_snapshot  = 1'b1;
          w_nextState = S_LOAD_F;
          w_nextIdx   = 5'd0;
        end
      end
      S_LOAD_F: begin
        w_wr   = 1'b1;
        w_adr  = (r_idx == 5'd0) ? L_FLEN : (L_FLEN - 5'd1);
        w_fSel = L_FLEN - r_idx;
        if (r_idx == L_FLEN) begin
          w_nextState = S_LOAD_G;
          w_nextIdx   = 5'd0;
        end else begin
          w_nextIdx = r_idx + 5'd1;
        end
      end
      S_LOAD_G: begin
        w_wr   = 1'b1;
        w_adr  = (r_idx == 5'd0) ? (L_GBASE + L_GLEN) : (L_GBASE + L_GLEN - 5'd1);
        w_gSel = L_GLEN - r_idx;
        if (r_idx == L_GLEN) begin
          w_nextState = (DAT_DELAY > 1) ? S_DRAIN : S_UPDATE;
          w_nextIdx   = 5'd0;
        end else begin
          w_nextIdx = r_idx + 5'd1;
        end
      end
      S_DRAIN: begin
        if (r_idx == L_DRAIN_LAST) begin
          w_nextState = S_UPDATE;
          w_nextIdx   = 5'd0;
        end else begin
          w_nextIdx = r_idx + 5'd1;
        end
      end
      S_UPDATE: begin
        w_update = 1'b1;
        if (r_pending || apply_i) begin
          w_snapshot  = 1'b1;
          w_nextState = S_LOAD_F;
          w_nextIdx   = 5'd0;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextIdx   = 5'd0;
      end
    endcase
  end

  // One-deep request memory: any number of applies during a load become one reload.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_snapshot) begin
      w_pendingNext = 1'b0;
    end else if (apply_i && (r_state != S_IDLE)) begin
      w_pendingNext = 1'b1;
    end
  end

  // Select the active-bank value for the slot being written this cycle.
  always_comb begin
    w_wrDat = '0;
    if (r_state == S_LOAD_F) begin
      for (int k = 0; k <= FLEN; k++) begin
        if (w_fSel == 5'(k)) begin
          w_wrDat = r_fAct[k];
        end
      end
    end else if (r_state == S_LOAD_G) begin
      for (int k = 0; k <= GLEN; k++) begin
        if (w_gSel == 5'(k)) begin
          w_wrDat = r_gAct[k];
        end
      end
    end
  end

  // Sequencer state, slot counter, pending request and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 5'd0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_idx     <= w_nextIdx;
      r_pending <= w_pendingNext;
      r_done    <= (r_state == S_UPDATE);
    end
  end

  // Staging register file, written by software at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= FLEN; k++) r_fStg[k] <= '0;
      for (int k = 0; k <= GLEN; k++) r_gStg[k] <= '0;
    end else begin
      r_fStg <= w_fStgNext;
      r_gStg <= w_gStgNext;
    end
  end

  // Active bank: frozen copy of the staging file taken at the start of each load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= FLEN; k++) r_fAct[k] <= '0;
      for (int k = 0; k <= GLEN; k++) r_gAct[k] <= '0;
    end else if (w_snapshot) begin
      r_fAct <= w_fStgNext;
      r_gAct <= w_gStgNext;
    end
  end

  // Data delay line matching the FIR's write-enable to B1-enable register depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DAT_DELAY; k++) r_datPipe[k] <= '0;
    end else begin
      r_datPipe[0] <= w_wrDat;
      for (int k = 1; k < DAT_DELAY; k++) r_datPipe[k] <= r_datPipe[k-1];
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = r_done;
  assign coeff_wr_o     = w_wr;
  assign coeff_adr_o    = w_adr;
  assign coeff_update_o = w_update;
  assign coeff_dat_o    = r_datPipe[DAT_DELAY-1];

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// tb_biquad8_pole_coeff_loader
// Directed and random stimulus against a timeline model of the loader plus a
// behavioural model of the downstream pole FIR's B1/B2 coefficient chains.
module tb_biquad8_pole_coeff_loader;

   localparam int FLEN    = 7;
   localparam int GLEN    = 8;
   localparam int CW      = 18;
   localparam int DD      = 2;
   localparam int NSLOT   = FLEN + 1 + GLEN + 1;
   localparam int MAXC    = 1024;

   logic          clk;
   logic          rst;
   logic          stg_wr_i;
   logic [4:0]    stg_adr_i;
   logic [CW-1:0] stg_dat_i;
   logic          apply_i;
   logic          busy_o;
   logic          done_o;
   logic [4:0]    coeff_adr_o;
   logic          coeff_wr_o;
   logic          coeff_update_o;
   logic [CW-1:0] coeff_dat_o;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          upd;
      logic          wr;
      logic [4:0]    adr;
      logic [CW-1:0] dat;
   } obs_t;

   obs_t          obsArr [MAXC];
   obs_t          expArr [MAXC];
   logic [CW-1:0] stgModel  [32];
   logic [CW-1:0] snapModel [32];
   logic [CW-1:0] fB1 [0:FLEN];
   logic [CW-1:0] fB2 [0:FLEN];
   logic [CW-1:0] gB1 [0:GLEN];
   logic [CW-1:0] gB2 [0:GLEN];
   bit            hWr  [DD];
   int            hAdr [DD];

   int cyc;
   int total;
   int bad;
   int loadEnd;
   bit pending;
   int base;

   biquad8_pole_coeff_loader #(
      .FLEN(FLEN), .GLEN(GLEN), .CW(CW), .DAT_DELAY(DD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stg_wr_i(stg_wr_i),
      .stg_adr_i(stg_adr_i),
      .stg_dat_i(stg_dat_i),
      .apply_i(apply_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .coeff_adr_o(coeff_adr_o),
      .coeff_wr_o(coeff_wr_o),
      .coeff_update_o(coeff_update_o),
      .coeff_dat_o(coeff_dat_o)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit validAdr(input int a);
      return (a >= 0 && a <= FLEN) || (a >= 16 && a <= 16 + GLEN);
   endfunction

   // Expected timeline of one load whose first write lands in cycle s.
   function automatic void addLoad(input int s);
      int a;
      int j;
      logic [CW-1:0] v;
      for (int i = 0; i < NSLOT; i++) begin
         if (i <= FLEN) begin
            a = (i == 0) ? FLEN : FLEN - 1;
            v = snapModel[FLEN - i];
         end else begin
            j = i - FLEN - 1;
            a = (j == 0) ? 16 + GLEN : 16 + GLEN - 1;
            v = snapModel[16 + GLEN - j];
         end
         if (s + i < MAXC) begin
            expArr[s + i].wr  = 1'b1;
            expArr[s + i].adr = 5'(a);
         end
         if (s + i + DD < MAXC) expArr[s + i + DD].dat = v;
      end
      for (int c = s; c < s + NSLOT + DD; c++) begin
         if (c < MAXC) expArr[c].busy = 1'b1;
      end
      if (s + NSLOT + DD - 1 < MAXC) expArr[s + NSLOT + DD - 1].upd = 1'b1;
      if (s + NSLOT + DD < MAXC) expArr[s + NSLOT + DD].done = 1'b1;
   endfunction

   function automatic void takeSnapshot();
      for (int k = 0; k < 32; k++) snapModel[k] = stgModel[k];
      pending = 1'b0;
      loadEnd = cyc + NSLOT + DD;
      addLoad(cyc + 1);
   endfunction

   // Reference model: applies the cycle's inputs at the level of the rules.
   function automatic void modelCycle(input bit rstIn, input bit applyIn, input bit wrIn,
                                      input int adrIn, input logic [CW-1:0] datIn);
      if (rstIn) begin
         for (int k = 0; k < 32; k++) stgModel[k] = '0;
         for (int c = cyc; c < MAXC; c++) expArr[c] = '0;
         pending = 1'b0;
         loadEnd = -100;
         return;
      end
      if (wrIn && validAdr(adrIn)) stgModel[adrIn] = datIn;
      if (applyIn) begin
         if (cyc <= loadEnd) pending = 1'b1;
         else takeSnapshot();
      end
      if (cyc == loadEnd && pending) takeSnapshot();
   endfunction

   // Downstream FIR chains: cross DSP loads on its own address and the chain
   // shifts on every write (junk first, real values after).
   function automatic void firLoad(input int a, input logic [CW-1:0] d);
      if (a == FLEN || a == FLEN - 1) begin
         if (a == FLEN) fB1[FLEN] = d;
         for (int k = FLEN - 1; k > 0; k--) fB1[k] = fB1[k - 1];
         fB1[0] = d;
      end else if (a == 16 + GLEN || a == 16 + GLEN - 1) begin
         if (a == 16 + GLEN) gB1[GLEN] = d;
         for (int k = GLEN - 1; k > 0; k--) gB1[k] = gB1[k - 1];
         gB1[0] = d;
      end
   endfunction

   // The FIR pairs each write with the data DD cycles later; B2 takes B1
   // including the data that arrives alongside the update strobe.
   function automatic void firStep();
      if (rst) begin
         for (int k = 0; k < DD; k++) hWr[k] = 1'b0;
         return;
      end
      if (hWr[DD - 1]) firLoad(hAdr[DD - 1], coeff_dat_o);
      for (int k = DD - 1; k > 0; k--) begin
         hWr[k]  = hWr[k - 1];
         hAdr[k] = hAdr[k - 1];
      end
      hWr[0]  = coeff_wr_o;
      hAdr[0] = int'(coeff_adr_o);
      if (coeff_update_o) begin
         for (int k = 0; k <= FLEN; k++) fB2[k] = fB1[k];
         for (int k = 0; k <= GLEN; k++) gB2[k] = gB1[k];
      end
   endfunction

   // Drive one cycle of inputs, sample outputs mid-cycle, advance past the edge.
   task automatic applyStimulus(input bit rstIn, input bit applyIn, input bit wrIn,
                                input int adrIn, input logic [CW-1:0] datIn);
      rst       = rstIn;
      apply_i   = applyIn;
      stg_wr_i  = wrIn;
      stg_adr_i = 5'(adrIn);
      stg_dat_i = datIn;
      modelCycle(rstIn, applyIn, wrIn, adrIn, datIn);
      @(negedge clk);
      obsArr[cyc].busy = busy_o;
      obsArr[cyc].done = done_o;
      obsArr[cyc].upd  = coeff_update_o;
      obsArr[cyc].wr   = coeff_wr_o;
      obsArr[cyc].adr  = coeff_adr_o;
      obsArr[cyc].dat  = coeff_dat_o;
      firStep();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, '0);
   endtask

   task automatic checkOutput(input int from, input int upto, input string tag);
      for (int c = from; c < upto; c++) begin
         total++;
         assert (obsArr[c] === expArr[c]) else begin
            bad++;
            $error("[TB] FAIL %s cycle+%0d observed=%h expected=%h (busy,done,upd,wr,adr,dat)",
                   tag, c - from, obsArr[c], expArr[c]);
         end
      end
   endtask

   task automatic checkFir(input string tag);
      for (int k = 0; k <= FLEN; k++) begin
         total++;
         assert (fB2[k] === snapModel[k]) else begin
            bad++;
            $error("[TB] FAIL %s F_B2[%0d] observed=%h expected=%h", tag, k, fB2[k], snapModel[k]);
         end
      end
      for (int k = 0; k <= GLEN; k++) begin
         total++;
         assert (gB2[k] === snapModel[16 + k]) else begin
            bad++;
            $error("[TB] FAIL %s G_B2[%0d] observed=%h expected=%h", tag, k, gB2[k], snapModel[16 + k]);
         end
      end
   endtask

   initial begin
      cyc     = 0;
      total   = 0;
      bad     = 0;
      loadEnd = -100;
      pending = 1'b0;
      for (int k = 0; k < MAXC; k++) expArr[k] = '0;
      for (int k = 0; k < 32; k++) begin
         stgModel[k]  = '0;
         snapModel[k] = '0;
      end
      for (int k = 0; k < DD; k++) begin
         hWr[k]  = 1'b0;
         hAdr[k] = 0;
      end

      $display("[TB] reset state");
      applyStimulus(1'b1, 1'b0, 1'b0, 0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, '0);
      checkOutput(0, cyc, "reset");

      $display("[TB] ramp load F=0x100+k G=0x200+k");
      for (int k = 0; k <= FLEN; k++) applyStimulus(1'b0, 1'b0, 1'b1, k, CW'(32'h100 + k));
      for (int k = 0; k <= GLEN; k++) applyStimulus(1'b0, 1'b0, 1'b1, 16 + k, CW'(32'h200 + k));
      base = cyc;
      applyStimulus(1'b0, 1'b1, 1'b0, 0, '0);
      idle(24);
      checkOutput(base, cyc, "ramp");
      checkFir("ramp_fir");

      $display("[TB] write-first snapshot");
      base = cyc;
      applyStimulus(1'b0, 1'b1, 1'b1, 3, 18'h3FFFF);
      idle(4);
      applyStimulus(1'b0, 1'b0, 1'b1, 3, 18'h00001);
      idle(20);
      checkOutput(base, cyc, "wfirst");
      checkFir("wfirst_fir");

      $display("[TB] applies collapse while busy");
      base = cyc;
      for (int c = 0; c < 46; c++) begin
         applyStimulus(1'b0, (c == 0 || c == 4 || c == 9), (c == 12), 0, CW'($urandom));
      end
      checkOutput(base, cyc, "pending");
      checkFir("pending_fir");

      $display("[TB] reset during load");
      base = cyc;
      for (int c = 0; c < 31; c++) applyStimulus((c == 10), (c == 0), 1'b0, 0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, '0);
      idle(22);
      checkOutput(base, cyc, "abort");
      checkFir("abort_fir");

      $display("[TB] out-of-map staging addresses");
      base = cyc;
      for (int k = 0; k <= FLEN; k++) applyStimulus(1'b0, 1'b0, 1'b1, k, CW'($urandom));
      for (int k = 0; k <= GLEN; k++) applyStimulus(1'b0, 1'b0, 1'b1, 16 + k, CW'($urandom));
      applyStimulus(1'b0, 1'b0, 1'b1, 8, 18'h2AAAA);
      applyStimulus(1'b0, 1'b0, 1'b1, 15, 18'h2AAAA);
      applyStimulus(1'b0, 1'b0, 1'b1, 25, 18'h2AAAA);
      applyStimulus(1'b0, 1'b0, 1'b1, 31, 18'h2AAAA);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, '0);
      idle(22);
      checkOutput(base, cyc, "ignored");
      checkFir("ignored_fir");

      $display("[TB] random traffic");
      base = cyc;
      for (int c = 0; c < 300; c++) begin
         applyStimulus(1'b0, ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, 31)), CW'($urandom));
      end
      idle(25);
      checkOutput(base, cyc, "random");
      checkFir("random_fir");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
